// File: rtl/video_stream_monitor.sv
// -----------------------------------------------------------------------------
// video_stream_monitor
//
// AXI4-Stream video pass-through with a built-in timing/geometry monitor.
// Each input component is reduced from IN_COMP_W to OUT_COMP_W bits, either by
// truncation or by round-half-up with saturation. The result goes through a
// 1-deep registered slice. The monitor observes accepted input beats and
// reports the following:
//   * frame and line periods in clk cycles
//   * pixels per line and lines per frame
//   * SOF/EOL toggles
//   * sticky protocol-error flags
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   s_axis_video_*            input stream (tdata/tvalid/tready/tuser/tlast)
//   m_axis_video_*            output stream, all outputs registered
//   clr                       synchronous clear of statistics and error flags
//   frame_period/line_period  cycles between the last two accepted SOF/EOL
//   pixels_per_line           beats in the last completed line
//   lines_per_frame           EOL beats in the last completed frame
//   frame_toggle/line_toggle  flip on each accepted SOF/EOL
//   stat_valid                both periods measured at least once
//   err_line_len, err_sof     sticky protocol errors
// -----------------------------------------------------------------------------
module video_stream_monitor #(
   parameter int IN_COMP_W  = 10,
   parameter int OUT_COMP_W = 8,
   parameter int NUM_COMP   = 3,
   parameter int IN_PAD     = 2,
   parameter int ROUND      = 0,
   parameter int CNT_W      = 24
) (
   input  logic                                  clk,
   input  logic                                  rstn,
   input  logic [NUM_COMP*IN_COMP_W+IN_PAD-1:0]  s_axis_video_tdata,
   input  logic                                  s_axis_video_tvalid,
   output logic                                  s_axis_video_tready,
   input  logic                                  s_axis_video_tuser,
   input  logic                                  s_axis_video_tlast,
   output logic [NUM_COMP*OUT_COMP_W-1:0]        m_axis_video_tdata,
   output logic                                  m_axis_video_tvalid,
   output logic                                  m_axis_video_tuser,
   output logic                                  m_axis_video_tlast,
   input  logic                                  m_axis_video_tready,
   input  logic                                  clr,
   output logic [CNT_W-1:0]                      frame_period,
   output logic [CNT_W-1:0]                      line_period,
   output logic [15:0]                           pixels_per_line,
   output logic [15:0]                           lines_per_frame,
   output logic                                  frame_toggle,
   output logic                                  line_toggle,
   output logic                                  stat_valid,
   output logic                                  err_line_len,
   output logic                                  err_sof
);

   localparam int IN_W    = NUM_COMP*IN_COMP_W+IN_PAD;
   localparam int OUT_W   = NUM_COMP*OUT_COMP_W;
   localparam int DIFF    = IN_COMP_W-OUT_COMP_W;
   localparam int HALF_SH = (DIFF > 0) ? DIFF-1 : 0;
   // Rounding increment: half an output LSB, or nothing for truncation/pass-through
   localparam logic [IN_COMP_W:0] HALF = (ROUND != 0 && DIFF > 0) ?
      ({{IN_COMP_W{1'b0}}, 1'b1} << HALF_SH) : {(IN_COMP_W+1){1'b0}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Reduce one component; an overflow of the rounding add saturates to all-ones
   function automatic logic [OUT_COMP_W-1:0] conv_comp(input logic [IN_COMP_W-1:0] c);
      logic [IN_COMP_W:0] sum;
      sum = {1'b0, c} + HALF;
      if (sum[IN_COMP_W]) begin
         conv_comp = {OUT_COMP_W{1'b1}};
      end else begin
         conv_comp = sum[IN_COMP_W-1 -: OUT_COMP_W];
      end
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      sat_inc_cnt = (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   function automatic logic [15:0] sat_inc_16(input logic [15:0] v);
      sat_inc_16 = (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Pad bits carry no information
   generate
      if (IN_PAD > 0) begin : g_pad
         logic pad_unused_s;
         assign pad_unused_s = ^s_axis_video_tdata[IN_W-1 -: IN_PAD];
      end
   endgenerate

   // ---------------- state ----------------
   logic [OUT_W-1:0] m_data_q, m_data_d;
   logic             m_valid_q, m_valid_d;
   logic             m_user_q, m_user_d;
   logic             m_last_q, m_last_d;
   logic [CNT_W-1:0] cyc_f_q, cyc_f_d, cyc_l_q, cyc_l_d;
   logic [CNT_W-1:0] frame_period_q, frame_period_d, line_period_q, line_period_d;
   logic [15:0]      pix_q, pix_d, ppl_q, ppl_d, lc_q, lc_d, lpf_q, lpf_d;
   logic             frame_tog_q, frame_tog_d, line_tog_q, line_tog_d;
   logic [1:0]       sof_cnt_q, sof_cnt_d, eol_cnt_q, eol_cnt_d;
   logic             stat_valid_q, stat_valid_d;
   logic             err_line_len_q, err_line_len_d, err_sof_q, err_sof_d;

   logic             s_ready_s, beat_s, stat_beat_s, sof_s, eol_s;
   logic [OUT_W-1:0] conv_s;
   logic [15:0]      pix_base_s, pix_inc_s, lc_base_s;

   // Handshake and component conversion
   always_comb begin
      s_ready_s = m_axis_video_tready | ~m_valid_q;
      beat_s    = s_axis_video_tvalid & s_ready_s;
      conv_s    = {OUT_W{1'b0}};
      for (int k = 0; k < NUM_COMP; k++) begin
         conv_s[k*OUT_COMP_W +: OUT_COMP_W] = conv_comp(s_axis_video_tdata[k*IN_COMP_W +: IN_COMP_W]);
      end
   end

   // Output slice: load on a beat, drain when downstream takes it, hold when stalled
   always_comb begin
      m_data_d  = m_data_q;
      m_user_d  = m_user_q;
      m_last_d  = m_last_q;
      m_valid_d = m_valid_q;
      if (beat_s) begin
         m_data_d  = conv_s;
         m_user_d  = s_axis_video_tuser;
         m_last_d  = s_axis_video_tlast;
         m_valid_d = 1'b1;
      end else if (m_axis_video_tready) begin
         m_valid_d = 1'b0;
      end else begin
         m_valid_d = m_valid_q;
      end
   end

   // Monitor: a beat in a clr cycle is ignored by the statistics
   always_comb begin
      stat_beat_s = beat_s & ~clr;
      sof_s       = stat_beat_s & s_axis_video_tuser;
      eol_s       = stat_beat_s & s_axis_video_tlast;
      // SOF mid-line restarts the line count before this beat is added
      pix_base_s  = (sof_s && pix_q != 16'd0) ? 16'd0 : pix_q;
      pix_inc_s   = sat_inc_16(pix_base_s);
      // SOF takes effect before EOL when both arrive on the same beat
      lc_base_s   = sof_s ? 16'd0 : lc_q;

      cyc_f_d        = sof_s ? CNT_ONE : sat_inc_cnt(cyc_f_q);
      cyc_l_d        = eol_s ? CNT_ONE : sat_inc_cnt(cyc_l_q);
      frame_period_d = sof_s ? cyc_f_q : frame_period_q;
      line_period_d  = eol_s ? cyc_l_q : line_period_q;
      lpf_d          = sof_s ? lc_q : lpf_q;
      lc_d           = eol_s ? sat_inc_16(lc_base_s) : lc_base_s;
      frame_tog_d    = frame_tog_q ^ sof_s;
      line_tog_d     = line_tog_q ^ eol_s;
      err_sof_d      = err_sof_q | (sof_s & (pix_q != 16'd0));
      // A length comparison needs at least one earlier measured line
      err_line_len_d = err_line_len_q | (eol_s & (eol_cnt_q != 2'd0) & (pix_inc_s != ppl_q));

      if (eol_s) begin
         ppl_d = pix_inc_s;
         pix_d = 16'd0;
      end else if (stat_beat_s) begin
         ppl_d = ppl_q;
         pix_d = pix_inc_s;
      end else begin
         ppl_d = ppl_q;
         pix_d = pix_q;
      end

      // The first latch of each period is partial, so validity needs two events of each
      sof_cnt_d    = (sof_s && sof_cnt_q != 2'd2) ? sof_cnt_q + 2'd1 : sof_cnt_q;
      eol_cnt_d    = (eol_s && eol_cnt_q != 2'd2) ? eol_cnt_q + 2'd1 : eol_cnt_q;
      stat_valid_d = stat_valid_q | ((sof_cnt_d == 2'd2) & (eol_cnt_d == 2'd2));

      if (clr) begin
         cyc_f_d        = CNT_ZERO;
         cyc_l_d        = CNT_ZERO;
         frame_period_d = CNT_ZERO;
         line_period_d  = CNT_ZERO;
         pix_d          = 16'd0;
         ppl_d          = 16'd0;
         lc_d           = 16'd0;
         lpf_d          = 16'd0;
         frame_tog_d    = 1'b0;
         line_tog_d     = 1'b0;
         sof_cnt_d      = 2'd0;
         eol_cnt_d      = 2'd0;
         stat_valid_d   = 1'b0;
         err_line_len_d = 1'b0;
         err_sof_d      = 1'b0;
      end else begin
         stat_valid_d   = stat_valid_d;
      end
   end

   // State register for slice and monitor
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_data_q       <= {OUT_W{1'b0}};
         m_valid_q      <= 1'b0;
         m_user_q       <= 1'b0;
         m_last_q       <= 1'b0;
         cyc_f_q        <= CNT_ZERO;
         cyc_l_q        <= CNT_ZERO;
         frame_period_q <= CNT_ZERO;
         line_period_q  <= CNT_ZERO;
         pix_q          <= 16'd0;
         ppl_q          <= 16'd0;
         lc_q           <= 16'd0;
         lpf_q          <= 16'd0;
         frame_tog_q    <= 1'b0;
         line_tog_q     <= 1'b0;
         sof_cnt_q      <= 2'd0;
         eol_cnt_q      <= 2'd0;
         stat_valid_q   <= 1'b0;
         err_line_len_q <= 1'b0;
         err_sof_q      <= 1'b0;
      end else begin
         m_data_q       <= m_data_d;
         m_valid_q      <= m_valid_d;
         m_user_q       <= m_user_d;
         m_last_q       <= m_last_d;
         cyc_f_q        <= cyc_f_d;
         cyc_l_q        <= cyc_l_d;
         frame_period_q <= frame_period_d;
         line_period_q  <= line_period_d;
         pix_q          <= pix_d;
         ppl_q          <= ppl_d;
         lc_q           <= lc_d;
         lpf_q          <= lpf_d;
         frame_tog_q    <= frame_tog_d;
         line_tog_q     <= line_tog_d;
         sof_cnt_q      <= sof_cnt_d;
         eol_cnt_q      <= eol_cnt_d;
         stat_valid_q   <= stat_valid_d;
         err_line_len_q <= err_line_len_d;
         err_sof_q      <= err_sof_d;
      end
   end

   assign s_axis_video_tready = s_ready_s;
   assign m_axis_video_tdata  = m_data_q;
   assign m_axis_video_tvalid = m_valid_q;
   assign m_axis_video_tuser  = m_user_q;
   assign m_axis_video_tlast  = m_last_q;
   assign frame_period        = frame_period_q;
   assign line_period         = line_period_q;
   assign pixels_per_line     = ppl_q;
   assign lines_per_frame     = lpf_q;
   assign frame_toggle        = frame_tog_q;
   assign line_toggle         = line_tog_q;
   assign stat_valid          = stat_valid_q;
   assign err_line_len        = err_line_len_q;
   assign err_sof             = err_sof_q;

endmodule

// File: tb/tb_video_stream_monitor.sv
// -----------------------------------------------------------------------------
// tb_video_stream_monitor
//
// Directed bench for video_stream_monitor. One ROUND=0 instance is monitored by
// an output scoreboard. A ROUND=1 instance shares the input stream and is used
// for the rounding vectors.
// -----------------------------------------------------------------------------
module tb_video_stream_monitor;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] s_tdata;
   logic        s_tvalid, s_tuser, s_tlast;
   logic        s_tready;
   logic [23:0] m_tdata;
   logic        m_tvalid, m_tuser, m_tlast;
   logic        m_tready;
   logic        clr;
   logic [23:0] frame_period, line_period;
   logic [15:0] pixels_per_line, lines_per_frame;
   logic        frame_toggle, line_toggle, stat_valid, err_line_len, err_sof;

   logic        r1_s_tready;
   logic [23:0] r1_m_tdata;
   logic        r1_m_tvalid;
   logic        unused_r1_user, unused_r1_last;
   logic [23:0] unused_r1_fp, unused_r1_lp;
   logic [15:0] unused_r1_ppl, unused_r1_lpf;
   logic        unused_r1_ft, unused_r1_lt, unused_r1_sv, unused_r1_el, unused_r1_es;

   int          checks = 0;
   int          errors = 0;
   int          in_cnt = 0;
   int          out_cnt = 0;
   logic [25:0] exp_q[$];
   logic        stall_prev = 1'b0;
   logic [25:0] held;

   always #5 clk = ~clk;

   video_stream_monitor #(.ROUND(0)) dut (
      .clk(clk), .rstn(rstn),
      .s_axis_video_tdata(s_tdata), .s_axis_video_tvalid(s_tvalid),
      .s_axis_video_tready(s_tready), .s_axis_video_tuser(s_tuser),
      .s_axis_video_tlast(s_tlast),
      .m_axis_video_tdata(m_tdata), .m_axis_video_tvalid(m_tvalid),
      .m_axis_video_tuser(m_tuser), .m_axis_video_tlast(m_tlast),
      .m_axis_video_tready(m_tready), .clr(clr),
      .frame_period(frame_period), .line_period(line_period),
      .pixels_per_line(pixels_per_line), .lines_per_frame(lines_per_frame),
      .frame_toggle(frame_toggle), .line_toggle(line_toggle),
      .stat_valid(stat_valid), .err_line_len(err_line_len), .err_sof(err_sof)
   );

   video_stream_monitor #(.ROUND(1)) dut_r1 (
      .clk(clk), .rstn(rstn),
      .s_axis_video_tdata(s_tdata), .s_axis_video_tvalid(s_tvalid),
      .s_axis_video_tready(r1_s_tready), .s_axis_video_tuser(s_tuser),
      .s_axis_video_tlast(s_tlast),
      .m_axis_video_tdata(r1_m_tdata), .m_axis_video_tvalid(r1_m_tvalid),
      .m_axis_video_tuser(unused_r1_user), .m_axis_video_tlast(unused_r1_last),
      .m_axis_video_tready(1'b1), .clr(clr),
      .frame_period(unused_r1_fp), .line_period(unused_r1_lp),
      .pixels_per_line(unused_r1_ppl), .lines_per_frame(unused_r1_lpf),
      .frame_toggle(unused_r1_ft), .line_toggle(unused_r1_lt),
      .stat_valid(unused_r1_sv), .err_line_len(unused_r1_el), .err_sof(unused_r1_es)
   );

   task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Truncation: top 8 bits of each 10-bit component
   function automatic logic [23:0] exp_conv(input logic [31:0] d);
      exp_conv = {d[29:22], d[19:12], d[9:2]};
   endfunction

   task automatic send(input logic u, input logic l, input logic [31:0] d);
      logic acc;
      int   n;
      s_tvalid = 1'b1; s_tuser = u; s_tlast = l; s_tdata = d;
      acc = 1'b0; n = 0;
      while (!acc && n < 64) begin
         @(negedge clk);
         acc = s_tready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         check_eq("accept_timeout", {95'd0, acc}, 96'd1);
      end else begin
         exp_q.push_back({u, l, exp_conv(d)});
         in_cnt++;
      end
      s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic send_frame(input int lines, input int ppl, input int seed);
      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < ppl; p++) begin
            send(l == 0 && p == 0, p == ppl-1, {2'b01, 30'(seed*977 + l*131 + p*7)});
         end
      end
   endtask

   task automatic check_stats(input string tag, input logic [23:0] fp, input logic [23:0] lp,
                              input logic [15:0] ppl, input logic [15:0] lpf, input logic sv,
                              input logic el, input logic es);
      check_eq({tag, "_frame_period"}, {72'd0, frame_period}, {72'd0, fp});
      check_eq({tag, "_line_period"}, {72'd0, line_period}, {72'd0, lp});
      check_eq({tag, "_ppl"}, {80'd0, pixels_per_line}, {80'd0, ppl});
      check_eq({tag, "_lpf"}, {80'd0, lines_per_frame}, {80'd0, lpf});
      check_eq({tag, "_flags"}, {93'd0, stat_valid, err_line_len, err_sof}, {93'd0, sv, el, es});
   endtask

   task automatic check_zero_stats(input string tag);
      check_eq(tag, {11'd0, frame_period, line_period, pixels_per_line, lines_per_frame,
                     frame_toggle, line_toggle, stat_valid, err_line_len, err_sof}, 96'd0);
   endtask

   // Output scoreboard and stall-stability monitor
   always @(negedge clk) begin
      if (!rstn) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check_eq("hold_valid", {95'd0, m_tvalid}, 96'd1);
            check_eq("hold_data", {70'd0, m_tuser, m_tlast, m_tdata}, {70'd0, held});
         end
         if (m_tvalid && m_tready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               check_eq("extra_beat", 96'(exp_q.size()), 96'd1);
            end else begin
               check_eq("out_beat", {70'd0, m_tuser, m_tlast, m_tdata}, {70'd0, exp_q.pop_front()});
            end
         end
         stall_prev = m_tvalid && !m_tready;
         held       = {m_tuser, m_tlast, m_tdata};
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit");
      $fatal(1);
   end

   initial begin
      logic done;
      rstn = 1'b0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
      s_tdata = 32'd0; m_tready = 1'b1; clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      check_eq("rst_m_valid", {93'd0, m_tvalid, m_tuser, m_tlast}, 96'd0);
      check_eq("rst_m_data", {72'd0, m_tdata}, 96'd0);
      check_eq("rst_s_ready", {95'd0, s_tready}, 96'd1);
      check_zero_stats("rst_stats");
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Truncation, pad ignored, 1-cycle latency
      send(1'b0, 1'b0, {2'b11, 10'h001, 10'h200, 10'h3FF});
      check_eq("lat_valid", {95'd0, m_tvalid}, 96'd1);
      check_eq("trunc_data", {72'd0, m_tdata}, {72'd0, 24'h0080FF});
      @(posedge clk);
      #1;
      check_eq("drain_valid", {95'd0, m_tvalid}, 96'd0);

      // Rounding instance
      send(1'b1, 1'b1, {2'b00, 10'h000, 10'h101, 10'h3FE});
      check_eq("round_valid", {95'd0, r1_m_tvalid}, 96'd1);
      check_eq("round_sat", {72'd0, r1_m_tdata}, {72'd0, 24'h0040FF});
      send(1'b0, 1'b0, {2'b00, 10'h002, 10'h3FD, 10'h1FE});
      check_eq("round_up", {72'd0, r1_m_tdata}, {72'd0, 24'h01FF80});
      check_eq("trunc_down", {72'd0, m_tdata}, {72'd0, 24'h00FF7F});

      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      check_zero_stats("clr0_stats");

      // Two 4x3 frames at full throughput
      send_frame(3, 4, 1);
      check_eq("f1_toggles", {94'd0, frame_toggle, line_toggle}, 96'd3);
      check_eq("f1_ppl", {80'd0, pixels_per_line}, 96'd4);
      check_eq("f1_line_period", {72'd0, line_period}, 96'd4);
      check_eq("f1_stat_valid", {95'd0, stat_valid}, 96'd0);
      send_frame(3, 4, 2);
      check_stats("f2", 24'd12, 24'd4, 16'd4, 16'd3, 1'b1, 1'b0, 1'b0);
      check_eq("f2_toggles", {94'd0, frame_toggle, line_toggle}, 96'd0);

      // Line-length error, sticky
      for (int p = 0; p < 5; p++) send(1'b0, p == 4, 32'h1234_5670 + 32'(p));
      check_eq("len5_err", {94'd0, err_line_len, err_sof}, 96'd2);
      check_eq("len5_ppl", {80'd0, pixels_per_line}, 96'd5);
      for (int p = 0; p < 4; p++) send(1'b0, p == 3, 32'h0ABC_DEF0 + 32'(p));
      check_eq("len_sticky", {95'd0, err_line_len}, 96'd1);
      // SOF injected at pixel 2
      send(1'b0, 1'b0, 32'h0000_0111);
      send(1'b0, 1'b0, 32'h0000_0222);
      check_eq("pre_sof_err", {95'd0, err_sof}, 96'd0);
      send(1'b1, 1'b0, 32'h0000_0333);
      check_eq("sof_err", {95'd0, err_sof}, 96'd1);
      check_eq("sof_lpf", {80'd0, lines_per_frame}, 96'd5);
      send(1'b0, 1'b0, 32'h0000_0444);
      send(1'b0, 1'b0, 32'h0000_0555);
      send(1'b0, 1'b1, 32'h0000_0666);
      check_eq("restart_ppl", {80'd0, pixels_per_line}, 96'd4);

      // Clear, with a SOF beat in the clr cycle that must not be counted
      clr = 1'b1;
      send(1'b1, 1'b0, 32'h3FFF_FFFF);
      clr = 1'b0;
      check_zero_stats("clr_stats");
      send(1'b0, 1'b0, 32'h0000_1000);
      send(1'b0, 1'b0, 32'h0000_2000);
      send(1'b0, 1'b1, 32'h0000_3000);
      check_eq("clr_beat_ppl", {80'd0, pixels_per_line}, 96'd3);
      check_eq("clr_flags", {93'd0, frame_toggle, line_toggle, err_sof}, 96'd2);
      // SOF and EOL on the same beat
      send(1'b1, 1'b1, 32'h0000_4000);
      check_eq("sofeol_lpf", {80'd0, lines_per_frame}, 96'd1);
      send(1'b1, 1'b0, 32'h0000_5000);
      check_eq("sofeol_lc", {80'd0, lines_per_frame}, 96'd1);

      // Reset mid-line
      send(1'b1, 1'b0, 32'h0000_6000);
      send(1'b0, 1'b0, 32'h0000_7000);
      rstn = 1'b0;
      #1;
      check_eq("mid_rst_m", {69'd0, m_tvalid, m_tuser, m_tlast, m_tdata}, 96'd0);
      check_eq("mid_rst_s_ready", {95'd0, s_tready}, 96'd1);
      check_zero_stats("mid_rst_stats");
      exp_q.delete();
      in_cnt = 0;
      out_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      send_frame(3, 4, 3);
      send_frame(3, 4, 4);
      check_stats("post_rst", 24'd12, 24'd4, 16'd4, 16'd3, 1'b1, 1'b0, 1'b0);

      // Random downstream stalls
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            done = 1'b1;
         end
         begin
            while (!done) begin
               m_tready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join
      m_tready = 1'b1;
      for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
      @(negedge clk);
      check_eq("drain_empty", 96'(exp_q.size()), 96'd0);
      check_eq("beat_count", 96'(out_cnt), 96'(in_cnt));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
